// File: rtl/apb_spi_pkg.sv
// Shared definitions for the SPI side of the APB-to-SPI bridge.
//   - spi_state_t : sequencer states, one-hot encoded
//   - entry field positions for a {rw, addr, wdata} command entry
//   - frame_bits(): SPI frame length for a given address/data width
package apb_spi_pkg;

    typedef enum logic [7:0] {
        IDLE       = 8'b0000_0001,
        FETCH      = 8'b0000_0010,
        WAIT_VALID = 8'b0000_0100,
        CS_SETUP   = 8'b0000_1000,
        SHIFT      = 8'b0001_0000,
        CS_HOLD    = 8'b0010_0000,
        PUSH       = 8'b0100_0000,
        GAP        = 8'b1000_0000
    } spi_state_t;

    // The data field always starts at bit 0, whatever the width.
    localparam int DATA_LSB = 0;

    function automatic int frame_bits(input int width);
        return 2 * width + 1;
    endfunction

    function automatic int rw_bit(input int width);
        return 2 * width;
    endfunction

    function automatic int addr_msb(input int width);
        return 2 * width - 1;
    endfunction

    function automatic int addr_lsb(input int width);
        return width;
    endfunction

    function automatic int data_msb(input int width);
        return width - 1;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator for the SPI sequencer.
// Counts CLK_DIV system clocks per SCLK half-period and toggles SCLK at the
// terminal count. rise/fall are single-cycle strobes asserted in the cycle
// whose closing edge makes SCLK go high/low, so the caller can act on the
// same edge. When en is low the counter and SCLK are held at zero, so every
// enable starts with a full half-period of SCLK low.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   en   : run the divider
//   sclk : SPI clock, idle low
//   rise : SCLK goes high on the next clock edge
//   fall : SCLK goes low on the next clock edge
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          tc;

    assign tc   = en && (cnt == CW'(CLK_DIV - 1));
    assign rise = tc && !sclk;
    assign fall = tc && sclk;

    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (tc) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_fifo_ctrl.sv
// SPI-side sequencer of the APB-to-SPI bridge.
// Pops {rw, addr, wdata} entries from the write FIFO and sends each as one
// SPI mode-0 frame of 2*WIDTH+1 bits, MSB first. Read entries (rw=0) send
// zeros in the data phase and push the captured MISO data phase into the
// read FIFO; if that FIFO is full the data is dropped and rd_drop is set.
// Ports:
//   PCLK, PRESET        : system clock, asynchronous active-high reset
//   ctrl_en             : allow new frames to start
//   err_clr             : clear rd_drop (a simultaneous drop wins)
//   w_empty/w_valid/w_dout, w_rd_en : write FIFO read port
//   r_full, r_wr_en/r_din           : read FIFO write port
//   SCLK, CS_N, MOSI, MISO          : SPI pins
//   busy        : not in IDLE
//   frame_done  : one-cycle pulse as CS_N deasserts
//   rd_drop     : sticky, read data discarded
module spi_fifo_ctrl
    import apb_spi_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic                 ctrl_en,
    input  logic                 err_clr,
    input  logic                 w_empty,
    input  logic                 w_valid,
    input  logic [2*WIDTH:0]     w_dout,
    output logic                 w_rd_en,
    input  logic                 r_full,
    output logic                 r_wr_en,
    output logic [WIDTH-1:0]     r_din,
    output logic                 SCLK,
    output logic                 CS_N,
    output logic                 MOSI,
    input  logic                 MISO,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 rd_drop
);

    localparam int FB       = frame_bits(WIDTH);
    localparam int RW_BIT   = rw_bit(WIDTH);
    localparam int DATA_MSB = data_msb(WIDTH);
    localparam int BCW      = $clog2(FB + 1);
    localparam int WCW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    spi_state_t       state, state_next;
    logic [FB-2:0]    tx_shift;   // bits still to send after the rw bit
    logic [FB-1:0]    tx_load;
    logic             rw_q;
    logic [WIDTH-1:0] rx_shift;
    logic [BCW-1:0]   bit_cnt;
    logic [WCW-1:0]   wait_cnt;
    logic             wait_done;
    logic             timed_state;
    logic             clk_en;
    logic             sclk_rise;
    logic             sclk_fall;
    logic             last_fall;
    logic             load;
    logic             hold_done;
    logic             drop_evt;

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk  (PCLK),
        .rst  (PRESET),
        .en   (clk_en),
        .sclk (SCLK),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    assign timed_state = (state == CS_SETUP) || (state == CS_HOLD) || (state == GAP);
    assign wait_done   = (wait_cnt == WCW'(CLK_DIV - 1));
    assign clk_en      = (state == SHIFT);
    assign last_fall   = sclk_fall && (bit_cnt == BCW'(FB - 1));
    assign load        = (state == WAIT_VALID) && w_valid;
    assign hold_done   = (state == CS_HOLD) && wait_done;
    assign drop_evt    = (state == PUSH) && r_full;
    assign busy        = (state != IDLE);

    // Read entries must not put the stale wdata field on the wire.
    always_comb begin
        tx_load = w_dout;
        if (!w_dout[RW_BIT]) begin
            tx_load[DATA_MSB:DATA_LSB] = '0;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output gets a default before the case, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        w_rd_en    = 1'b0;
        r_wr_en    = 1'b0;
        r_din      = '0;
        case (state)
            IDLE:       if (ctrl_en && !w_empty) state_next = FETCH;
            FETCH: begin
                w_rd_en    = 1'b1;
                state_next = WAIT_VALID;
            end
            WAIT_VALID: if (w_valid) state_next = CS_SETUP;
            CS_SETUP:   if (wait_done) state_next = SHIFT;
            SHIFT:      if (last_fall) state_next = CS_HOLD;
            CS_HOLD:    if (wait_done) state_next = rw_q ? GAP : PUSH;
            PUSH: begin
                if (!r_full) begin
                    r_wr_en = 1'b1;
                    r_din   = rx_shift;
                end
                state_next = GAP;
            end
            GAP:        if (wait_done) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tx_shift   <= '0;
            rw_q       <= 1'b0;
            rx_shift   <= '0;
            bit_cnt    <= '0;
            wait_cnt   <= '0;
            CS_N       <= 1'b1;
            MOSI       <= 1'b0;
            frame_done <= 1'b0;
            rd_drop    <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // Timed states run for exactly CLK_DIV cycles; the counter
            // restarts at every exit so consecutive timed states chain.
            if (timed_state && !wait_done) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            // The rw bit goes straight to MOSI so it is valid for the
            // first rising edge; the rest waits in tx_shift.
            if (load) begin
                tx_shift <= tx_load[FB-2:0];
                rw_q     <= w_dout[RW_BIT];
                MOSI     <= w_dout[RW_BIT];
                CS_N     <= 1'b0;
                bit_cnt  <= '0;
            end

            // Only the last WIDTH samples survive: the data phase.
            if (sclk_rise) begin
                rx_shift <= {rx_shift[WIDTH-2:0], MISO};
            end

            if (sclk_fall) begin
                MOSI     <= tx_shift[FB-2];
                tx_shift <= {tx_shift[FB-3:0], 1'b0};
                bit_cnt  <= bit_cnt + 1'b1;
            end

            if (hold_done) begin
                CS_N       <= 1'b1;
                frame_done <= 1'b1;
            end

            if (drop_evt) begin
                rd_drop <= 1'b1;
            end else if (err_clr) begin
                rd_drop <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_fifo_ctrl.sv
// Directed bench for spi_fifo_ctrl with a write-FIFO model, a MISO slave
// model and scoreboards for MOSI frames and read-FIFO pushes.
module tb_spi_fifo_ctrl;

    localparam int WIDTH      = 8;
    localparam int CLK_DIV    = 2;
    localparam int FB         = 2 * WIDTH + 1;
    localparam int LOW_CYCLES = FB * 2 * CLK_DIV + 2 * CLK_DIV;

    logic             PCLK = 1'b0;
    logic             PRESET;
    logic             ctrl_en;
    logic             err_clr;
    logic             w_empty = 1'b1;
    logic             w_valid = 1'b0;
    logic [FB-1:0]    w_dout = '0;
    logic             w_rd_en;
    logic             r_full;
    logic             r_wr_en;
    logic [WIDTH-1:0] r_din;
    logic             SCLK;
    logic             CS_N;
    logic             MOSI;
    logic             MISO = 1'b0;
    logic             busy;
    logic             frame_done;
    logic             rd_drop;

    spi_fifo_ctrl #(
        .WIDTH   (WIDTH),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .ctrl_en    (ctrl_en),
        .err_clr    (err_clr),
        .w_empty    (w_empty),
        .w_valid    (w_valid),
        .w_dout     (w_dout),
        .w_rd_en    (w_rd_en),
        .r_full     (r_full),
        .r_wr_en    (r_wr_en),
        .r_din      (r_din),
        .SCLK       (SCLK),
        .CS_N       (CS_N),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .busy       (busy),
        .frame_done (frame_done),
        .rd_drop    (rd_drop)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    logic [FB-1:0]    fifo_q[$];
    logic [FB-1:0]    exp_mosi_q[$];
    logic [WIDTH-1:0] exp_rd_q[$];
    logic [FB-1:0]    miso_word = '0;

    int rd_en_cnt = 0;
    int fd_cnt    = 0;
    int wr_cnt    = 0;
    int fall_cnt  = 0;
    int cap_n     = 0;
    int low_cnt   = 0;
    int high_cnt  = 0;

    logic          prev_cs    = 1'b1;
    logic          prev_sclk  = 1'b0;
    logic          seen_frame = 1'b0;
    logic          rd_pending = 1'b0;
    logic [FB-1:0] cap        = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Standard-mode write FIFO: data and w_valid appear in the cycle after
    // the w_rd_en cycle.
    always @(negedge PCLK) begin
        w_valid = 1'b0;
        if (rd_pending && fifo_q.size() > 0) begin
            w_dout  = fifo_q.pop_front();
            w_valid = 1'b1;
        end
        rd_pending = w_rd_en && !PRESET;
        w_empty    = (fifo_q.size() == 0);
    end

    // Pin monitor, scoreboard consumer and MISO slave model.
    always @(negedge PCLK) begin
        if (PRESET) begin
            prev_cs    = 1'b1;
            prev_sclk  = 1'b0;
            seen_frame = 1'b0;
            cap_n      = 0;
            fall_cnt   = 0;
            low_cnt    = 0;
            high_cnt   = 0;
            MISO       = 1'b0;
        end else begin
            if (w_rd_en) rd_en_cnt++;
            if (frame_done) fd_cnt++;
            if (r_wr_en) begin
                wr_cnt++;
                check("rd_push_expected", exp_rd_q.size() > 0, 1);
                if (exp_rd_q.size() > 0) check("r_din", r_din, exp_rd_q.pop_front());
            end
            if (!CS_N) begin
                if (prev_cs) begin
                    if (seen_frame) check("cs_gap_min", high_cnt >= CLK_DIV, 1);
                    cap      = '0;
                    cap_n    = 0;
                    fall_cnt = 0;
                    low_cnt  = 0;
                end
                low_cnt++;
                if (!prev_sclk && SCLK) begin
                    cap = {cap[FB-2:0], MOSI};
                    cap_n++;
                end
                if (prev_sclk && !SCLK) fall_cnt++;
            end else begin
                if (!prev_cs) begin
                    check("frame_done_at_cs_rise", frame_done, 1);
                    check("sclk_rises", cap_n, FB);
                    check("cs_low_cycles", low_cnt, LOW_CYCLES);
                    check("frame_expected", exp_mosi_q.size() > 0, 1);
                    if (exp_mosi_q.size() > 0) check("mosi_frame", cap, exp_mosi_q.pop_front());
                    seen_frame = 1'b1;
                    high_cnt   = 0;
                end
                high_cnt++;
            end
            MISO      = (!CS_N && fall_cnt < FB) ? miso_word[FB-1-fall_cnt] : 1'b0;
            prev_cs   = CS_N;
            prev_sclk = SCLK;
        end
    end

    task automatic tick();
        @(negedge PCLK);
        #1;
    endtask

    task automatic enqueue(input logic [FB-1:0] entry, input bit expect_push, input logic [WIDTH-1:0] rd_data);
        fifo_q.push_back(entry);
        exp_mosi_q.push_back(entry[FB-1] ? entry : {entry[FB-1:WIDTH], {WIDTH{1'b0}}});
        if (!entry[FB-1] && expect_push) exp_rd_q.push_back(rd_data);
    endtask

    task automatic wait_frames(input int target, input string tag);
        int n = 0;
        while (fd_cnt < target && n < 400) begin
            tick();
            n++;
        end
        check(tag, fd_cnt >= target, 1);
    endtask

    task automatic wait_falls(input int target, input string tag);
        int n = 0;
        while (!(!CS_N && fall_cnt >= target) && n < 400) begin
            tick();
            n++;
        end
        check(tag, (!CS_N && fall_cnt >= target), 1);
    endtask

    int base_rd;
    int base_fd;
    int base_wr;

    initial begin
        PRESET  = 1'b1;
        ctrl_en = 1'b0;
        err_clr = 1'b0;
        r_full  = 1'b0;
        repeat (3) tick();

        check("rst_cs_n", CS_N, 1);
        check("rst_sclk", SCLK, 0);
        check("rst_mosi", MOSI, 0);
        check("rst_w_rd_en", w_rd_en, 0);
        check("rst_r_wr_en", r_wr_en, 0);
        check("rst_r_din", r_din, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_rd_drop", rd_drop, 0);
        PRESET = 1'b0;
        repeat (2) tick();

        // Single write frame.
        base_rd = rd_en_cnt; base_fd = fd_cnt; base_wr = wr_cnt;
        enqueue(17'h1_5AC3, 1'b0, '0);
        ctrl_en = 1'b1;
        wait_frames(base_fd + 1, "t1_frame_timeout");
        repeat (8) tick();
        check("t1_w_rd_en_pulses", rd_en_cnt - base_rd, 1);
        check("t1_no_push", wr_cnt - base_wr, 0);
        check("t1_frame_done_pulses", fd_cnt - base_fd, 1);
        check("t1_idle", busy, 0);

        // Read frame, data A5; then a read whose wdata field must be masked.
        miso_word = {9'h155, 8'hA5};
        base_fd = fd_cnt; base_wr = wr_cnt;
        enqueue(17'h0_3C00, 1'b1, 8'hA5);
        wait_frames(base_fd + 1, "t2_frame_timeout");
        repeat (8) tick();
        check("t2_push_once", wr_cnt - base_wr, 1);
        miso_word = {9'h0AA, 8'h3C};
        base_fd = fd_cnt; base_wr = wr_cnt;
        enqueue(17'h0_12FF, 1'b1, 8'h3C);
        wait_frames(base_fd + 1, "t2b_frame_timeout");
        repeat (8) tick();
        check("t2b_push_once", wr_cnt - base_wr, 1);
        check("t2b_no_drop", rd_drop, 0);

        // Read with the read FIFO full: drop, then clear.
        r_full = 1'b1;
        miso_word = {9'h155, 8'hA5};
        base_fd = fd_cnt; base_wr = wr_cnt;
        enqueue(17'h0_7E00, 1'b0, '0);
        wait_frames(base_fd + 1, "t3_frame_timeout");
        repeat (8) tick();
        check("t3_no_push", wr_cnt - base_wr, 0);
        check("t3_rd_drop_set", rd_drop, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        check("t3_rd_drop_cleared", rd_drop, 0);

        // err_clr in the same cycle as a drop: the drop wins.
        base_fd = fd_cnt;
        enqueue(17'h0_2200, 1'b0, '0);
        wait_frames(base_fd + 1, "t3b_frame_timeout");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        check("t3b_drop_wins", rd_drop, 1);
        r_full  = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        repeat (6) tick();
        check("t3b_rd_drop_cleared", rd_drop, 0);

        // Two queued writes back to back.
        base_rd = rd_en_cnt; base_fd = fd_cnt;
        enqueue(17'h1_A55A, 1'b0, '0);
        enqueue(17'h1_0F0F, 1'b0, '0);
        wait_frames(base_fd + 2, "t4_frames_timeout");
        repeat (8) tick();
        check("t4_w_rd_en_pulses", rd_en_cnt - base_rd, 2);
        check("t4_frame_done_pulses", fd_cnt - base_fd, 2);

        // Reset in the middle of the shift phase.
        enqueue(17'h1_3377, 1'b0, '0);
        wait_falls(7, "t5_shift_timeout");
        PRESET = 1'b1;
        #1;
        check("t5_rst_cs_n", CS_N, 1);
        check("t5_rst_sclk", SCLK, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_mosi", MOSI, 0);
        exp_mosi_q.delete();
        repeat (3) tick();
        PRESET = 1'b0;
        base_rd = rd_en_cnt;
        repeat (20) tick();
        check("t5_stays_idle", busy, 0);
        check("t5_no_fetch", rd_en_cnt - base_rd, 0);
        check("t5_cs_n_high", CS_N, 1);

        // ctrl_en dropped mid-frame with two entries queued.
        miso_word = {9'h155, 8'h5A};
        base_rd = rd_en_cnt; base_fd = fd_cnt; base_wr = wr_cnt;
        enqueue(17'h0_4400, 1'b1, 8'h5A);
        enqueue(17'h1_8181, 1'b0, '0);
        wait_falls(3, "t6_shift_timeout");
        ctrl_en = 1'b0;
        wait_frames(base_fd + 1, "t6_frame_timeout");
        repeat (40) tick();
        check("t6_one_fetch", rd_en_cnt - base_rd, 1);
        check("t6_one_frame_done", fd_cnt - base_fd, 1);
        check("t6_push_completed", wr_cnt - base_wr, 1);
        check("t6_idle", busy, 0);
        ctrl_en = 1'b1;
        wait_frames(base_fd + 2, "t6_resume_timeout");
        repeat (8) tick();
        check("t6_second_fetch", rd_en_cnt - base_rd, 2);
        check("mosi_scoreboard_drained", exp_mosi_q.size(), 0);
        check("rd_scoreboard_drained", exp_rd_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
